// File: rtl/predecode_redirect_ctrl.sv
// predecode_redirect_ctrl
//   Fetch-2 controller sitting behind the per-lane pre-decoders. Finds the oldest
//   predicted-taken control lane in a bundle, trims the younger lanes, and issues one
//   registered redirect to fetch-1 over a valid/ready handshake. After the handshake
//   it drains the in-flight wrong-path bundle for one cycle. A backend flush overrides
//   everything.
//
//   Optional return address stack: define PREDECODE_RAS_EN to build it. Without it,
//   returns use the lane target, calls push nothing, rasPtr_o is tied to 0 and
//   flushRasPtr_i is ignored.
//
// Ports
//   clk, reset         clock, asynchronous active-low reset
//   bundleValid_i      pre-decoded bundle present
//   pc_i               per-lane PC, lane i at [i*SIZE_PC +: SIZE_PC]
//   laneValid_i        lane holds a real instruction
//   isInstCtrl_i       per-lane control flag
//   isInstRtr_i        per-lane return flag
//   ctrlType_i         per-lane type: 01 call, 10 jump, 11 conditional
//   targetAddr_i       per-lane pre-decoded target
//   prediction_i       per-lane direction prediction
//   stall_o            bundle not accepted this cycle
//   laneMask_o         accepted lanes (combinational)
//   redirectValid_o    redirect request to fetch-1
//   redirectPC_o       redirect target
//   redirectReady_i    fetch-1 accepts the redirect
//   flush_i            backend flush
//   flushRasPtr_i      RAS top pointer restored on flush
//   rasPtr_o           RAS top pointer, checkpointed by the backend

module predecode_redirect_ctrl #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned SIZE_PC     = 32,
  parameter int unsigned RAS_DEPTH   = 8,
  localparam int unsigned RAS_PTR    = $clog2(RAS_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bundleValid_i,
  input  logic [SIZE_PC*FETCH_WIDTH-1:0] pc_i,
  input  logic [FETCH_WIDTH-1:0]         laneValid_i,
  input  logic [FETCH_WIDTH-1:0]         isInstCtrl_i,
  input  logic [FETCH_WIDTH-1:0]         isInstRtr_i,
  input  logic [2*FETCH_WIDTH-1:0]       ctrlType_i,
  input  logic [SIZE_PC*FETCH_WIDTH-1:0] targetAddr_i,
  input  logic [FETCH_WIDTH-1:0]         prediction_i,
  output logic                           stall_o,
  output logic [FETCH_WIDTH-1:0]         laneMask_o,
  output logic                           redirectValid_o,
  output logic [SIZE_PC-1:0]             redirectPC_o,
  input  logic                           redirectReady_i,
  input  logic                           flush_i,
  input  logic [RAS_PTR-1:0]             flushRasPtr_i,
  output logic [RAS_PTR-1:0]             rasPtr_o
);

  typedef enum logic [1:0] {StRun, StWait, StDrain} state_e;

  state_e               state_q, state_d;
  logic                 rdr_valid_q, rdr_valid_d;
  logic [SIZE_PC-1:0]   rdr_pc_q, rdr_pc_d;

  logic [FETCH_WIDTH-1:0] taken, keep;
  logic                   scan_seen, hit, accept, fire;
  logic [SIZE_PC-1:0]     sel_target, target;

`ifdef PREDECODE_RAS_EN
  localparam int unsigned CntW = RAS_PTR + 1;

  logic [SIZE_PC-1:0] ras_q [RAS_DEPTH];
  logic [RAS_PTR-1:0] ras_ptr_q, ras_ptr_d, ras_top;
  logic [CntW-1:0]    ras_cnt_q, ras_cnt_d;
  logic [SIZE_PC-1:0] sel_pc;
  logic               sel_rtr, sel_call, do_pop, do_push;
`endif

  // Oldest taken lane wins; lanes up to and including it are kept.
  always_comb begin
    scan_seen  = 1'b0;
    taken      = '0;
    keep       = '0;
    sel_target = '0;
`ifdef PREDECODE_RAS_EN
    sel_pc     = '0;
    sel_rtr    = 1'b0;
    sel_call   = 1'b0;
`endif
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      taken[i] = laneValid_i[i] & isInstCtrl_i[i] &
                 (isInstRtr_i[i] | (ctrlType_i[2*i +: 2] == 2'b01) |
                  (ctrlType_i[2*i +: 2] == 2'b10) |
                  ((ctrlType_i[2*i +: 2] == 2'b11) & prediction_i[i]));
      keep[i] = ~scan_seen;
      if (taken[i] && !scan_seen) begin
        sel_target = targetAddr_i[i*SIZE_PC +: SIZE_PC];
`ifdef PREDECODE_RAS_EN
        sel_pc   = pc_i[i*SIZE_PC +: SIZE_PC];
        sel_rtr  = isInstRtr_i[i];
        // A lane flagged as return is never treated as a call.
        sel_call = ~isInstRtr_i[i] & (ctrlType_i[2*i +: 2] == 2'b01);
`endif
      end
      scan_seen = scan_seen | taken[i];
    end
    hit = scan_seen;
  end

  assign accept     = (state_q == StRun) & bundleValid_i & ~flush_i;
  assign fire       = accept & hit;
  assign stall_o    = (state_q != StRun) & ~flush_i;
  assign laneMask_o = accept ? (keep & laneValid_i) : '0;

`ifdef PREDECODE_RAS_EN
  assign ras_top  = ras_ptr_q - RAS_PTR'(1);
  assign do_pop   = fire & sel_rtr & (ras_cnt_q != '0);
  assign do_push  = fire & sel_call;
  assign target   = do_pop ? ras_q[ras_top] : sel_target;
  assign rasPtr_o = ras_ptr_q;

  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (flush_i) begin
      // Backend checkpoint is authoritative: treat every entry as live.
      ras_ptr_d = flushRasPtr_i;
      ras_cnt_d = CntW'(RAS_DEPTH);
    end else if (do_pop) begin
      ras_ptr_d = ras_top;
      ras_cnt_d = ras_cnt_q - CntW'(1);
    end else if (do_push) begin
      // Wrapping push overwrites the oldest entry; count saturates.
      ras_ptr_d = ras_ptr_q + RAS_PTR'(1);
      if (ras_cnt_q != CntW'(RAS_DEPTH)) begin
        ras_cnt_d = ras_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_q[ras_ptr_q] <= sel_pc + SIZE_PC'(8);
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{pc_i, flushRasPtr_i};
  assign target        = sel_target;
  assign rasPtr_o      = '0;
`endif

  always_comb begin
    state_d     = state_q;
    rdr_valid_d = rdr_valid_q;
    rdr_pc_d    = rdr_pc_q;
    if (flush_i) begin
      // A pending redirect is dropped without ever being handed over.
      state_d     = StRun;
      rdr_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (fire) begin
            state_d     = StWait;
            rdr_valid_d = 1'b1;
            rdr_pc_d    = target;
          end
        end
        StWait: begin
          if (rdr_valid_q && redirectReady_i) begin
            state_d     = StDrain;
            rdr_valid_d = 1'b0;
          end
        end
        StDrain: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      rdr_valid_q <= 1'b0;
      rdr_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      rdr_valid_q <= rdr_valid_d;
      rdr_pc_q    <= rdr_pc_d;
    end
  end

  assign redirectValid_o = rdr_valid_q;
  assign redirectPC_o    = rdr_pc_q;

endmodule

// File: tb/tb_predecode_redirect_ctrl.sv
// Bench for predecode_redirect_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model of the controller.

module tb_predecode_redirect_ctrl;
  localparam int FW    = 4;
  localparam int PCW   = 32;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              bundleValid_i;
  logic [FW*PCW-1:0] pc_i, targetAddr_i;
  logic [FW-1:0]     laneValid_i, isInstCtrl_i, isInstRtr_i, prediction_i;
  logic [2*FW-1:0]   ctrlType_i;
  logic              stall_o;
  logic [FW-1:0]     laneMask_o;
  logic              redirectValid_o;
  logic [PCW-1:0]    redirectPC_o;
  logic              redirectReady_i, flush_i;
  logic [PW-1:0]     flushRasPtr_i, rasPtr_o;

  always #5 clk = ~clk;

  predecode_redirect_ctrl #(
    .FETCH_WIDTH(FW),
    .SIZE_PC    (PCW),
    .RAS_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bundleValid_i  (bundleValid_i),
    .pc_i           (pc_i),
    .laneValid_i    (laneValid_i),
    .isInstCtrl_i   (isInstCtrl_i),
    .isInstRtr_i    (isInstRtr_i),
    .ctrlType_i     (ctrlType_i),
    .targetAddr_i   (targetAddr_i),
    .prediction_i   (prediction_i),
    .stall_o        (stall_o),
    .laneMask_o     (laneMask_o),
    .redirectValid_o(redirectValid_o),
    .redirectPC_o   (redirectPC_o),
    .redirectReady_i(redirectReady_i),
    .flush_i        (flush_i),
    .flushRasPtr_i  (flushRasPtr_i),
    .rasPtr_o       (rasPtr_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: 0 = running, 1 = waiting for handshake, 2 = draining.
  int          m_st;
  bit          m_v;
  logic [31:0] m_pc;
  logic [2:0]  m_ptr;
`ifdef PREDECODE_RAS_EN
  int          m_cnt;
  logic [31:0] m_mem [DEPTH];
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_v   = 1'b0;
    m_pc  = '0;
    m_ptr = '0;
`ifdef PREDECODE_RAS_EN
    m_cnt = 0;
`endif
  endtask

  task automatic clear_bundle();
    bundleValid_i = 1'b0;
    pc_i          = '0;
    targetAddr_i  = '0;
    laneValid_i   = '0;
    isInstCtrl_i  = '0;
    isInstRtr_i   = '0;
    ctrlType_i    = '0;
    prediction_i  = '0;
  endtask

  // Four valid plain lanes starting at base.
  task automatic seq_bundle(input logic [31:0] base);
    clear_bundle();
    bundleValid_i = 1'b1;
    laneValid_i   = 4'hf;
    for (int i = 0; i < FW; i++) begin
      pc_i[i*PCW +: PCW]         = base + 32'(4 * i);
      targetAddr_i[i*PCW +: PCW] = 32'h0050_0000 + 32'(16 * i);
    end
  endtask

  task automatic set_ctrl(input int lane, input logic rtr, input logic [1:0] ct,
                          input logic pred, input logic [31:0] tgt);
    isInstCtrl_i[lane]            = 1'b1;
    isInstRtr_i[lane]             = rtr;
    ctrlType_i[2*lane +: 2]       = ct;
    prediction_i[lane]            = pred;
    targetAddr_i[lane*PCW +: PCW] = tgt;
  endtask

  // Called just after a falling edge with inputs already driven: checks outputs,
  // advances the model across the next rising edge, returns on the next falling edge.
  task automatic cycle();
    int          k;
    int          ct;
    bit          stall;
    logic [3:0]  em;
    logic [31:0] tgt;
    #1;
    k = -1;
    for (int i = FW - 1; i >= 0; i--) begin
      ct = int'(ctrlType_i[2*i +: 2]);
      if (laneValid_i[i] && isInstCtrl_i[i] &&
          (isInstRtr_i[i] || ct == 1 || ct == 2 || (ct == 3 && prediction_i[i]))) k = i;
    end
    stall = (m_st != 0) && !flush_i;
    if (stall || !bundleValid_i || flush_i) em = 4'h0;
    else if (k < 0)                         em = laneValid_i;
    else                                    em = laneValid_i & 4'((1 << (k + 1)) - 1);
    check("stall",         64'(stall_o),         64'(stall));
    check("laneMask",      64'(laneMask_o),      64'(em));
    check("redirectValid", 64'(redirectValid_o), 64'(m_v));
    check("redirectPC",    64'(redirectPC_o),    64'(m_pc));
    check("rasPtr",        64'(rasPtr_o),        64'(m_ptr));

    if (flush_i) begin
      m_st = 0;
      m_v  = 1'b0;
`ifdef PREDECODE_RAS_EN
      m_ptr = flushRasPtr_i;
      m_cnt = DEPTH;
`endif
    end else if (m_st == 0) begin
      if (bundleValid_i && k >= 0) begin
        tgt = targetAddr_i[k*PCW +: PCW];
`ifdef PREDECODE_RAS_EN
        if (isInstRtr_i[k]) begin
          if (m_cnt > 0) begin
            m_ptr = m_ptr - 3'd1;
            tgt   = m_mem[m_ptr];
            m_cnt = m_cnt - 1;
          end
        end else if (ctrlType_i[2*k +: 2] == 2'b01) begin
          m_mem[m_ptr] = pc_i[k*PCW +: PCW] + 32'd8;
          m_ptr        = m_ptr + 3'd1;
          if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
        end
`endif
        m_v  = 1'b1;
        m_pc = tgt;
        m_st = 1;
      end
    end else if (m_st == 1) begin
      if (redirectReady_i) begin
        m_v  = 1'b0;
        m_st = 2;
      end
    end else begin
      m_st = 0;
    end
    @(negedge clk);
  endtask

  logic [31:0] exp_pc;
  logic [2:0]  exp_ptr;

  initial begin
    clear_bundle();
    redirectReady_i = 1'b1;
    flush_i         = 1'b0;
    flushRasPtr_i   = '0;
    reset           = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_stall", 64'(stall_o),         64'(0));
    check("reset_mask",  64'(laneMask_o),      64'(0));
    check("reset_valid", 64'(redirectValid_o), 64'(0));
    check("reset_pc",    64'(redirectPC_o),    64'(0));
    check("reset_ptr",   64'(rasPtr_o),        64'(0));
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Predicted-taken conditional at lane 2.
    seq_bundle(32'h0040_0000);
    set_ctrl(2, 1'b0, 2'b11, 1'b1, 32'h0040_0100);
    #1 check("t1_mask", 64'(laneMask_o), 64'(4'b0111));
    cycle();
    check("t1_pc", 64'(redirectPC_o), 64'(32'h0040_0100));
    cycle();
    cycle();
    clear_bundle();
    cycle();

    // Not-taken conditional: whole bundle accepted.
    seq_bundle(32'h0040_0020);
    set_ctrl(0, 1'b0, 2'b11, 1'b0, 32'h0040_0200);
    #1 check("t2_mask", 64'(laneMask_o), 64'(4'b1111));
    check("t2_stall", 64'(stall_o), 64'(0));
    cycle();
    cycle();

    // Call then matching return.
    seq_bundle(32'h0040_000c);
    set_ctrl(1, 1'b0, 2'b01, 1'b0, 32'h0040_1000);
    repeat (3) cycle();
    seq_bundle(32'h0040_1000);
    set_ctrl(0, 1'b1, 2'b10, 1'b0, 32'h0000_0999);
    cycle();
`ifdef PREDECODE_RAS_EN
    exp_pc = 32'h0040_0018;
`else
    exp_pc = 32'h0000_0999;
`endif
    check("t3_ret_pc", 64'(redirectPC_o), 64'(exp_pc));
    repeat (2) cycle();

    // Fetch-1 back-pressure for five cycles.
    seq_bundle(32'h0040_2000);
    set_ctrl(3, 1'b0, 2'b10, 1'b0, 32'h0040_3000);
    redirectReady_i = 1'b0;
    cycle();
    repeat (5) begin
      check("t4_hold_pc", 64'(redirectPC_o), 64'(32'h0040_3000));
      cycle();
    end
    redirectReady_i = 1'b1;
    cycle();
    check("t4_valid_drop", 64'(redirectValid_o), 64'(0));
    cycle();

    // Nine calls into an eight-deep stack, then nine returns.
    for (int j = 0; j < 9; j++) begin
      seq_bundle(32'h0041_0000 + 32'(j * 256));
      set_ctrl(0, 1'b0, 2'b01, 1'b0, 32'h0060_0000 + 32'(j));
      repeat (3) cycle();
    end
    for (int j = 0; j < 9; j++) begin
      seq_bundle(32'h0042_0000 + 32'(j * 256));
      set_ctrl(0, 1'b1, 2'b10, 1'b0, 32'h0070_0000 + 32'(j));
      repeat (3) cycle();
    end

    // Flush while a redirect is pending.
    seq_bundle(32'h0043_0000);
    set_ctrl(1, 1'b0, 2'b10, 1'b0, 32'h0044_0000);
    redirectReady_i = 1'b0;
    repeat (2) cycle();
    flush_i       = 1'b1;
    flushRasPtr_i = 3'd3;
    cycle();
    flush_i = 1'b0;
`ifdef PREDECODE_RAS_EN
    exp_ptr = 3'd3;
`else
    exp_ptr = 3'd0;
`endif
    check("t6_valid", 64'(redirectValid_o), 64'(0));
    check("t6_ptr",   64'(rasPtr_o),        64'(exp_ptr));
    cycle();
    redirectReady_i = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset in the middle of a pending redirect.
    seq_bundle(32'h0045_0000);
    set_ctrl(0, 1'b0, 2'b01, 1'b0, 32'h0046_0000);
    redirectReady_i = 1'b0;
    cycle();
    #3 reset = 1'b0;
    #1;
    check("areset_valid", 64'(redirectValid_o), 64'(0));
    check("areset_stall", 64'(stall_o),         64'(0));
    check("areset_ptr",   64'(rasPtr_o),        64'(0));
    check("areset_pc",    64'(redirectPC_o),    64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_bundle();
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bundleValid_i = ($urandom_range(0, 3) != 0);
      laneValid_i   = 4'($urandom);
      isInstCtrl_i  = 4'($urandom);
      isInstRtr_i   = 4'($urandom) & 4'($urandom);
      ctrlType_i    = 8'($urandom);
      prediction_i  = 4'($urandom);
      for (int i = 0; i < FW; i++) begin
        pc_i[i*PCW +: PCW]         = $urandom & 32'hffff_fffc;
        targetAddr_i[i*PCW +: PCW] = $urandom & 32'hffff_fffc;
      end
      redirectReady_i = ($urandom_range(0, 2) != 0);
      flush_i         = ($urandom_range(0, 15) == 0);
      flushRasPtr_i   = 3'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
